// File: rtl/fpu_sp_pkg.sv
// Shared types and constants for the single-precision FPU datapaths.
package fpu_sp_pkg;
  typedef struct packed {logic sign; logic [7:0] exp; logic [22:0] man;} fp32_t;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_OVF  = 2 * EXP_BIAS + 1;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam int          MAN_W    = 24;
  localparam int          GRS_W    = 3;
  localparam int          EXT_W    = MAN_W + GRS_W;
  localparam int          LZC_W    = 5;

  function automatic logic is_nan(input fp32_t x);
    return (x.exp == EXP_MAX) && (x.man != '0);
  endfunction

  function automatic logic is_inf(input fp32_t x);
    return (x.exp == EXP_MAX) && (x.man == '0);
  endfunction
endpackage

// File: rtl/fpu_sp_lzc.sv
// Leading-zero counter over the 27-bit extended mantissa (all-zero input gives 27).
module fpu_sp_lzc
  import fpu_sp_pkg::*;
(
  input  logic [EXT_W-1:0] d,
  output logic [LZC_W-1:0] cnt
);
  always_comb begin
    cnt = LZC_W'(EXT_W);
    for (int i = 0; i < EXT_W; i++)
      if (d[i]) cnt = LZC_W'(EXT_W - 1 - i);
  end
endmodule

// File: rtl/fpu_sp_sub.sv
// Registered binary32 subtractor (a - b), RNE rounding, denormals flushed to zero.
// Define FPU_SP_SUB_INREG_EN to add an input register stage (latency 2).
module fpu_sp_sub
  import fpu_sp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        overflow_underflow_flag
);
  fp32_t a_q, b_q;

`ifdef FPU_SP_SUB_INREG_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
    end
`else
  assign a_q = a;
  assign b_q = b;
`endif

  logic sa, sb, eff_sub, swap;
  logic [30:0] mag_a, mag_b, mag_big, mag_small;
  assign sa      = a_q.sign;
  assign sb      = ~b_q.sign;
  assign eff_sub = sa ^ sb;
  // Denormal operands collapse to zero magnitude before ordering.
  assign mag_a   = (a_q.exp == '0) ? '0 : {a_q.exp, a_q.man};
  assign mag_b   = (b_q.exp == '0) ? '0 : {b_q.exp, b_q.man};
  assign swap    = mag_b > mag_a;
  assign mag_big   = swap ? mag_b : mag_a;
  assign mag_small = swap ? mag_a : mag_b;

  logic             s_big;
  logic [7:0]       e_big, e_small, d;
  logic [MAN_W-1:0] m_big, m_small;
  assign s_big   = swap ? sb : sa;
  assign e_big   = mag_big[30:23];
  assign e_small = mag_small[30:23];
  assign m_big   = {|e_big, mag_big[22:0]};
  assign m_small = {|e_small, mag_small[22:0]};
  assign d       = e_big - e_small;

  logic [49:0]      wide;
  logic [EXT_W-1:0] aligned, dif;
  logic [EXT_W:0]   sum;
  assign wide    = {m_small, 26'b0} >> d;
  assign aligned = (d >= 8'd26) ? {26'b0, |m_small} : {wide[49:24], |wide[23:0]};
  assign sum     = {1'b0, m_big, 3'b0} + {1'b0, aligned};
  assign dif     = {m_big, 3'b0} - aligned;

  logic [LZC_W-1:0] lz;
  fpu_sp_lzc u_lzc (.d(dif), .cnt(lz));

  logic [EXT_W-1:0] mant_n;
  logic [9:0]       exp_n;
  always_comb begin
    mant_n = '0;
    exp_n  = '0;
    if (!eff_sub) begin
      if (sum[EXT_W]) begin
        mant_n = {sum[27:2], sum[1] | sum[0]};
        exp_n  = {2'b0, e_big} + 10'd1;
      end else begin
        mant_n = sum[26:0];
        exp_n  = {2'b0, e_big};
      end
    end else begin
      mant_n = dif << lz;
      exp_n  = {2'b0, e_big} - {5'b0, lz};
    end
  end

  logic        rnd_up;
  logic [24:0] m_r;
  logic [9:0]  exp_r;
  logic [22:0] frac;
  assign rnd_up = mant_n[2] & (mant_n[1] | mant_n[0] | mant_n[3]);
  assign m_r    = {1'b0, mant_n[26:3]} + {24'b0, rnd_up};
  assign exp_r  = exp_n + {9'b0, m_r[24]};
  assign frac   = m_r[24] ? m_r[23:1] : m_r[22:0];

  logic [31:0] res_d;
  logic        flag_d;
  always_comb begin
    res_d  = {s_big, exp_r[7:0], frac};
    flag_d = 1'b0;
    if (is_nan(a_q) || is_nan(b_q) || (is_inf(a_q) && is_inf(b_q) && eff_sub))
      res_d = QNAN;
    else if (is_inf(a_q))
      res_d = {sa, EXP_MAX, 23'b0};
    else if (is_inf(b_q))
      res_d = {sb, EXP_MAX, 23'b0};
    else if (mag_big == '0)
      res_d = {sa & sb, 31'b0};
    else if (eff_sub && dif == '0)
      res_d = '0;
    else if (exp_r[9] || exp_r == '0) begin
      res_d  = {s_big, 31'b0};
      flag_d = 1'b1;
    end else if (exp_r >= 10'(EXP_OVF)) begin
      res_d  = {s_big, EXP_MAX, 23'b0};
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      result                  <= '0;
      overflow_underflow_flag <= 1'b0;
    end else begin
      result                  <= res_d;
      overflow_underflow_flag <= flag_d;
    end
endmodule

// File: tb/tb_fpu_sp_sub.sv
// Directed-vector bench for fpu_sp_sub; expected values worked out by hand.
module tb_fpu_sp_sub;
`ifdef FPU_SP_SUB_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, result;
  logic        flag;
  int          n_chk = 0;
  int          n_err = 0;

  fpu_sp_sub dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .result(result), .overflow_underflow_flag(flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] va, input logic [31:0] vb,
                     input logic [31:0] er, input logic ef);
    @(negedge clk);
    a = va;
    b = vb;
    repeat (LAT) @(posedge clk);
    #1;
    chk({tag, ".res"}, result, er);
    chk({tag, ".flg"}, {31'b0, flag}, {31'b0, ef});
  endtask

  logic [31:0] qa[4] = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h42F2A57A};
  logic [31:0] qb[4] = '{32'h40000000, 32'hC0000000, 32'h40000000, 32'h42F63F07};
  logic [31:0] qe[4] = '{32'hBF800000, 32'h40400000, 32'hC0400000, 32'hBFE66340};

  initial begin
    rst = 1'b1;
    a   = 32'h3F800000;
    b   = 32'h40000000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.res", result, 32'h0);
    chk("reset.flg", {31'b0, flag}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run("one_m_two",  32'h3F800000, 32'h40000000, 32'hBF800000, 1'b0);
    run("two_m_one",  32'h40000000, 32'h3F800000, 32'h3F800000, 1'b0);
    run("one_m_neg2", 32'h3F800000, 32'hC0000000, 32'h40400000, 1'b0);
    run("neg1_m_two", 32'hBF800000, 32'h40000000, 32'hC0400000, 1'b0);

    run("rnd1", 32'h42F2A57A, 32'h42F63F07, 32'hBFE66340, 1'b0);
    run("rnd2", 32'h42F2A57A, 32'hC2F63F07, 32'h43747240, 1'b0);
    run("rnd3", 32'hC2F2A57A, 32'h42F63F07, 32'hC3747240, 1'b0);
    run("rnd4", 32'h4712D003, 32'h42F63F07, 32'h471254E3, 1'b0);
    run("rnd5", 32'h3B0A697B, 32'hBB0BB906, 32'h3B8B1140, 1'b0);
    run("rnd6", 32'h47F24B37, 32'hCB0C972F, 32'h4B0E7BC5, 1'b0);

    run("cancel",    32'h42F2A5E3, 32'h42F2A5E3, 32'h00000000, 1'b0);
    run("overflow",  32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1);
    run("underflow", 32'h00800001, 32'h00800000, 32'h00000000, 1'b1);

    run("nan",        32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0);
    run("inf_m_inf",  32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0);
    run("inf_m_one",  32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0);
    run("one_m_inf",  32'h3F800000, 32'h7F800000, 32'hFF800000, 1'b0);
    run("denorm_a",   32'h00000001, 32'h3F800000, 32'hBF800000, 1'b0);

    // Back-to-back operands, one per cycle.
    for (int i = 0; i < 4 + LAT - 1; i++) begin
      @(negedge clk);
      if (i < 4) begin
        a = qa[i];
        b = qb[i];
      end
      @(posedge clk);
      #1;
      if (i >= LAT - 1) chk("stream", result, qe[i-LAT+1]);
    end

    // Reset between edges clears the registered overflow result at once.
    run("pre_rst", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst.res", result, 32'h0);
    chk("async_rst.flg", {31'b0, flag}, 32'h0);
    @(posedge clk);
    #1;
    chk("hold_rst.res", result, 32'h0);
    chk("hold_rst.flg", {31'b0, flag}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run("post_rst", 32'h40000000, 32'h3F800000, 32'h3F800000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
